// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state codes, opcodes,
// datapath mux selects and the packed control word produced by the output decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the controller state to its datapath control word.
// Unused state codes decode to an all-zero word.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
      end
      // Branch target is precomputed here so BRANCH only needs the compare.
      S_DECODE: ctrl_o.alu_src_b = ALUSRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Define MEM_WAIT_EN to make FETCH/MEMRD/MEMWR wait for mem_ready.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_o
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;
  logic       mem_stall;
  logic       fetch_hold;

`ifdef MEM_WAIT_EN
  assign mem_stall = ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_stall        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (!mem_stall) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state_d = S_MEMADR;
          OPCODE_W'(OP_RTYPE):                state_d = S_EXEC;
          OPCODE_W'(OP_BEQ):                  state_d = S_BRANCH;
          OPCODE_W'(OP_ADDI):                 state_d = S_ADDIEX;
          OPCODE_W'(OP_J):                    state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (!mem_stall) state_d = S_MEMWB;
      S_MEMWR:  if (!mem_stall) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // A stalled fetch keeps the read request up but must not latch IR or advance PC.
  assign fetch_hold = (state_q == S_FETCH) && mem_stall;

  assign pc_en      = (ctrl.pc_write & ~fetch_hold) | (ctrl.branch & zero);
  assign ir_write   = ctrl.ir_write & ~fetch_hold;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed steps push hand-computed
// expectations, a monitor pops and compares them on each falling clock or reset edge.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  // Output vector order:
  // {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],illegal_op}
  localparam logic [15:0] E_ZERO   = 16'b0000000000000000;
  localparam logic [15:0] E_FETCH  = 16'b1010100000100000;
  localparam logic [15:0] E_FWAIT  = 16'b0010000000100000;
  localparam logic [15:0] E_DEC    = 16'b0000000001100000;
  localparam logic [15:0] E_DECILL = 16'b0000000001100001;
  localparam logic [15:0] E_ADR    = 16'b0000000011000000;
  localparam logic [15:0] E_MRD    = 16'b0110000000000000;
  localparam logic [15:0] E_MWB    = 16'b0000001100000000;
  localparam logic [15:0] E_MWR    = 16'b0101000000000000;
  localparam logic [15:0] E_EXEC   = 16'b0000000010010000;
  localparam logic [15:0] E_ALUWB  = 16'b0000010100000000;
  localparam logic [15:0] E_BR1    = 16'b1000000010001010;
  localparam logic [15:0] E_BR0    = 16'b0000000010001010;
  localparam logic [15:0] E_ADDIWB = 16'b0000000100000000;
  localparam logic [15:0] E_JUMP   = 16'b1000000000000100;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  st;
    logic [15:0] ev;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] step_idx = 16'd0;

  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [15:0] ev);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e.idx = step_idx;
    e.st  = st;
    e.ev  = ev;
    exp_q.push_back(e);
    step_idx = step_idx + 16'd1;
  endtask

  task automatic go(input logic [5:0] op, input logic z, input logic [3:0] st, input logic [15:0] ev);
    step(1'b1, op, z, 1'b1, st, ev);
  endtask

  // Monitor: samples away from the rising edge, or just after an asynchronous reset.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
        n_checks++;
        if (state_o !== e.st) begin
          n_fail++;
          $display("FAIL step%0d state: got %0d expected %0d", e.idx, state_o, e.st);
        end
        n_checks++;
        if (act !== e.ev) begin
          n_fail++;
          $display("FAIL step%0d outputs: got %b expected %b", e.idx, act, e.ev);
        end
        $display("step%0d state=%0d outputs=%b", e.idx, state_o, act);
      end
    end
  end

  initial begin
    // Reset held three cycles, then released; FETCH follows on the next edge.
    repeat (3) step(1'b0, RT, 1'b0, 1'b1, 4'd0, E_ZERO);
    step(1'b1, RT, 1'b0, 1'b1, 4'd0, E_ZERO);

    // lw
    go(LW, 1'b0, 4'd1, E_FETCH);
    go(LW, 1'b0, 4'd2, E_DEC);
    go(LW, 1'b0, 4'd3, E_ADR);
    go(LW, 1'b0, 4'd4, E_MRD);
    go(LW, 1'b0, 4'd5, E_MWB);

    // beq taken, then not taken
    go(BEQ, 1'b1, 4'd1, E_FETCH);
    go(BEQ, 1'b1, 4'd2, E_DEC);
    go(BEQ, 1'b1, 4'd9, E_BR1);
    go(BEQ, 1'b0, 4'd1, E_FETCH);
    go(BEQ, 1'b0, 4'd2, E_DEC);
    go(BEQ, 1'b0, 4'd9, E_BR0);

`ifdef MEM_WAIT_EN
    // sw with waits in FETCH (2 cycles) and MEMWR (4 cycles)
    step(1'b1, SW, 1'b0, 1'b0, 4'd1, E_FWAIT);
    step(1'b1, SW, 1'b0, 1'b0, 4'd1, E_FWAIT);
    go(SW, 1'b0, 4'd1, E_FETCH);
    go(SW, 1'b0, 4'd2, E_DEC);
    go(SW, 1'b0, 4'd3, E_ADR);
    repeat (4) step(1'b1, SW, 1'b0, 1'b0, 4'd6, E_MWR);
    go(SW, 1'b0, 4'd6, E_MWR);
`else
    // sw with mem_ready low throughout: it must be ignored
    step(1'b1, SW, 1'b0, 1'b0, 4'd1, E_FETCH);
    step(1'b1, SW, 1'b0, 1'b0, 4'd2, E_DEC);
    step(1'b1, SW, 1'b0, 1'b0, 4'd3, E_ADR);
    step(1'b1, SW, 1'b0, 1'b0, 4'd6, E_MWR);
`endif

    // R-type
    go(RT, 1'b0, 4'd1, E_FETCH);
    go(RT, 1'b0, 4'd2, E_DEC);
    go(RT, 1'b0, 4'd7, E_EXEC);
    go(RT, 1'b0, 4'd8, E_ALUWB);

    // addi
    go(ADDI, 1'b0, 4'd1, E_FETCH);
    go(ADDI, 1'b0, 4'd2, E_DEC);
    go(ADDI, 1'b0, 4'd10, E_ADR);
    go(ADDI, 1'b0, 4'd11, E_ADDIWB);

    // j
    go(JMP, 1'b0, 4'd1, E_FETCH);
    go(JMP, 1'b0, 4'd2, E_DEC);
    go(JMP, 1'b0, 4'd12, E_JUMP);

    // Unsupported opcode: one-cycle illegal_op in DECODE, straight back to FETCH
    go(BAD, 1'b0, 4'd1, E_FETCH);
    go(BAD, 1'b0, 4'd2, E_DECILL);
    go(RT, 1'b0, 4'd1, E_FETCH);
    go(RT, 1'b0, 4'd2, E_DEC);
    go(RT, 1'b0, 4'd7, E_EXEC);

    // Asynchronous reset in the middle of EXEC, observed before the next edge
    @(negedge clk);
    #2;
    begin
      exp_t e;
      e.idx = step_idx;
      e.st  = 4'd0;
      e.ev  = E_ZERO;
      exp_q.push_back(e);
      step_idx = step_idx + 16'd1;
    end
    rst_n = 1'b0;
    step(1'b1, RT, 1'b0, 1'b1, 4'd0, E_ZERO);
    go(RT, 1'b0, 4'd1, E_FETCH);
    go(RT, 1'b0, 4'd2, E_DEC);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
